// File: rtl/debug_step_controller.sv
// Byte-command debug controller: pipeline clock-enable stepping/run/halt, breakpoint, probe readout.
// Optional macro DBG_READ_CHECKSUM_EN appends an XOR checksum byte to every READ reply.
module debug_step_controller #(
  parameter int NUM_PROBES = 32,
  parameter int PROBE_W    = 32,
  parameter int PC_W       = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  input  logic [NUM_PROBES*PROBE_W-1:0] probe_bus,
  input  logic [PC_W-1:0]               pipe_pc,
  output logic                          pipe_clk_en,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic                          halted
);
  // state   | meaning
  // IDLE    | halted, accepting any command
  // STEP    | pipeline enabled for cnt+1 more cycles
  // RUN     | pipeline enabled until HALT or breakpoint
  // SEND    | serialising shift register to tx port
  // BP_LOAD | collecting breakpoint address bytes
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STEP    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_BP_LOAD = 3'd4;

`ifdef DBG_READ_CHECKSUM_EN
  localparam int READ_BYTES = PROBE_W / 8 + 1;
`else
  localparam int READ_BYTES = PROBE_W / 8;
`endif
  localparam int PC_BYTES = PC_W / 8;
  localparam int CW_RD    = $clog2(READ_BYTES + 1);
  localparam int CW_PC    = $clog2(PC_BYTES + 1);
  localparam int CW_MAX   = (CW_RD > CW_PC) ? CW_RD : CW_PC;
  localparam int CNT_W    = (CW_MAX > 6) ? CW_MAX : 6;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [PROBE_W-1:0] shift;
  logic [PC_W-1:0]    bp_addr;
  logic               bp_en;
  logic               bp_hit;
  logic               first_run;
`ifdef DBG_READ_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic [1:0]         op;
  logic [5:0]         arg;
  logic               cmd_fire;
  logic               tx_fire;
  logic               bp_match;
  logic [PROBE_W-1:0] probe_sel;

  assign op        = cmd_data[7:6];
  assign arg       = cmd_data[5:0];
  assign cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_BP_LOAD);
  assign halted    = (state == S_IDLE);
  assign tx_valid  = (state == S_SEND);
  assign tx_data   = shift[7:0];
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign tx_fire   = tx_valid && tx_ready;
  // first RUN cycle never matches, so RUN from the breakpoint PC steps past it
  assign bp_match  = bp_en && (pipe_pc == bp_addr) && !first_run;

  always_comb begin
    pipe_clk_en = 1'b0;
    if (state == S_STEP)     pipe_clk_en = 1'b1;
    else if (state == S_RUN) pipe_clk_en = !bp_match;
  end

  // out-of-range slot indices read as zero
  always_comb begin
    probe_sel = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (arg == 6'(i)) probe_sel = probe_bus[i*PROBE_W +: PROBE_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift     <= '0;
      bp_addr   <= '0;
      bp_en     <= 1'b0;
      bp_hit    <= 1'b0;
      first_run <= 1'b0;
`ifdef DBG_READ_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      first_run <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (op)
              2'b00: begin
                shift <= probe_sel;
                cnt   <= CNT_W'(READ_BYTES - 1);
`ifdef DBG_READ_CHECKSUM_EN
                csum  <= '0;
`endif
                state <= S_SEND;
              end
              2'b01: begin
                cnt    <= CNT_W'(arg);
                bp_hit <= 1'b0;
                state  <= S_STEP;
              end
              2'b10: begin
                bp_hit    <= 1'b0;
                first_run <= 1'b1;
                state     <= S_RUN;
              end
              default: begin
                case (arg)
                  6'd1: begin
                    shift <= PROBE_W'({5'b0, bp_hit, bp_en, 1'b1});
                    cnt   <= '0;
                    state <= S_SEND;
                  end
                  6'd2: begin
                    cnt   <= '0;
                    state <= S_BP_LOAD;
                  end
                  6'd3: bp_en <= 1'b0;
                  default: ;
                endcase
              end
            endcase
          end
        end
        S_STEP: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_RUN: begin
          if (bp_match) begin
            bp_hit <= 1'b1;
            state  <= S_IDLE;
          end else if (cmd_fire && cmd_data == 8'hC0) begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (tx_fire) begin
`ifdef DBG_READ_CHECKSUM_EN
            csum <= csum ^ shift[7:0];
            // the byte after the last probe byte is the running XOR
            if (cnt == CNT_W'(1)) shift <= PROBE_W'(csum ^ shift[7:0]);
            else                  shift <= shift >> 8;
`else
            shift <= shift >> 8;
`endif
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        S_BP_LOAD: begin
          if (cmd_fire) begin
            bp_addr <= {cmd_data, bp_addr[PC_W-1:8]};
            if (cnt == CNT_W'(PC_BYTES - 1)) begin
              bp_en <= 1'b1;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
